dds_phase_accumulator: RTL and testbench

Phase accumulator stage of the DDS chain, directly upstream of the sine lookup. Each enabled cycle it adds a frequency tuning word (FTW) to an accumulator and presents the top ADDR_WIDTH bits, plus a phase offset, as a registered lookup address. FTW changes are accepted over a valid/ready handshake and applied either immediately or phase-continuously at the next accumulator wrap.

---
 rtl/dds_phase_accumulator_if.sv | 9 +
 rtl/dds_phase_accumulator.sv | 55 +++++
 tb/tb_dds_phase_accumulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dds_phase_accumulator_if.sv
// dds_phase_accumulator_if: FTW valid/ready handshake for the DDS phase accumulator.
interface dds_phase_accumulator_if #(parameter int ACC_WIDTH = 24);
   logic                 valid;
   logic                 ready;
   logic                 mode;
   logic [ACC_WIDTH-1:0] data;
   modport master (output valid, data, mode, input ready);
   modport slave  (input valid, data, mode, output ready);
endinterface

// File: rtl/dds_phase_accumulator.sv
// dds_phase_accumulator: FTW accumulator with immediate or wrap-aligned tuning updates,
// producing a registered, offset lookup address for the sine table.
module dds_phase_accumulator #(
   parameter int ACC_WIDTH  = 24,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  phase_clear,
   input  logic [ADDR_WIDTH-1:0] phase_offset,
   dds_phase_accumulator_if.slave ftw,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  addr_valid,
   output logic                  wrap
);
   typedef enum logic {RUN, PENDING} state_t;
   state_t               state, state_next;
   logic [ACC_WIDTH-1:0] acc, acc_next, ftw_active, active_next, ftw_shadow, shadow_next;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry, accept, apply;
   assign ftw.ready = (state == RUN);
   always_comb begin
      sum         = {1'b0, acc} + {1'b0, ftw_active};
      carry       = enable && sum[ACC_WIDTH];
      accept      = ftw.valid && (state == RUN);
      apply       = (state == PENDING) && (carry || phase_clear);
      state_next  = apply ? RUN : (accept && ftw.mode) ? PENDING : state;
      active_next = apply ? ftw_shadow : (accept && !ftw.mode) ? ftw.data : ftw_active;
      shadow_next = (accept && ftw.mode) ? ftw.data : ftw_shadow;
      acc_next    = phase_clear ? '0 : enable ? sum[ACC_WIDTH-1:0] : acc;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_next;
   end
   // Address uses the pre-edge accumulator, giving one cycle of acc-to-address latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         ftw_active <= '0;
         ftw_shadow <= '0;
         address    <= '0;
         addr_valid <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         acc        <= acc_next;
         ftw_active <= active_next;
         ftw_shadow <= shadow_next;
         address    <= acc[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_offset;
         addr_valid <= enable;
         wrap       <= carry && !phase_clear;
      end
   end
endmodule

// File: tb/tb_dds_phase_accumulator.sv
// tb_dds_phase_accumulator: scoreboard bench; driver pushes model predictions, monitor pops
// and compares the registered outputs every clock.
module tb_dds_phase_accumulator;
   localparam longint MOD = 64'd1 << 24;
   typedef struct packed {logic v; logic [7:0] a; logic w;} exp_t;

   logic       clk = 1'b1, rst_n = 1'b1, enable = 1'b0, phase_clear = 1'b0, addr_valid, wrap;
   logic [7:0] phase_offset = '0, address;
   int         errors = 0, checks = 0;
   longint     m_acc = 0, m_step = 0, m_shadow = 0;
   bit         m_pend = 1'b0;
   exp_t       q[$];

   dds_phase_accumulator_if #(.ACC_WIDTH(24)) ftw ();

   dds_phase_accumulator #(.ACC_WIDTH(24), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .phase_clear(phase_clear),
      .phase_offset(phase_offset), .ftw(ftw), .address(address),
      .addr_valid(addr_valid), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: one edge of the phase accumulator expressed as plain arithmetic.
   task automatic cyc(input bit en, input bit clr, input bit v, input logic [23:0] d,
                      input bit m, input logic [7:0] off);
      exp_t e;
      bit   carry;
      chk("ftw_ready", longint'(ftw.ready), longint'(!m_pend));
      enable = en; phase_clear = clr; phase_offset = off;
      ftw.valid = v; ftw.data = d; ftw.mode = m;
      carry = en && (m_acc + m_step >= MOD);
      e.v = en;
      e.a = 8'(((m_acc >> 16) + longint'(off)) % 256);
      e.w = carry && !clr;
      q.push_back(e);
      m_acc = clr ? 0 : en ? (m_acc + m_step) % MOD : m_acc;
      if (m_pend && (carry || clr)) begin
         m_step = m_shadow;
         m_pend = 1'b0;
      end else if (v && !m_pend) begin
         if (m) begin m_shadow = longint'(d); m_pend = 1'b1; end
         else m_step = longint'(d);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit en, input logic [7:0] off);
      for (int i = 0; i < n; i++) cyc(en, 1'b0, 1'b0, 24'h0, 1'b0, off);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_address", longint'(address), 0);
      chk("rst_addr_valid", longint'(addr_valid), 0);
      chk("rst_wrap", longint'(wrap), 0);
      chk("rst_ftw_ready", longint'(ftw.ready), 1);
      m_acc = 0; m_step = 0; m_shadow = 0; m_pend = 1'b0;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (q.size() == 0) chk("scoreboard_underflow", 1, 0);
            else begin
               e = q.pop_front();
               chk("addr_valid", longint'(addr_valid), longint'(e.v));
               chk("address", longint'(address), longint'(e.a));
               chk("wrap", longint'(wrap), longint'(e.w));
            end
         end
      end
   end

   initial begin
      ftw.valid = 1'b0; ftw.data = '0; ftw.mode = 1'b0;
      @(negedge clk);
      do_reset();
      cyc(1, 0, 1, 24'h010000, 0, 8'h00);
      idle(300, 1'b1, 8'h00);
      for (int i = 0; i < 600 && m_acc != 64'h800000; i++) idle(1, 1'b1, 8'h00);
      cyc(1, 0, 1, 24'h020000, 1, 8'h00);
      idle(200, 1'b1, 8'h00);
      cyc(1, 0, 1, 24'h010000, 0, 8'h00);
      idle(20, 1'b1, 8'h00);
      cyc(1, 0, 1, 24'h040000, 0, 8'h00);
      idle(100, 1'b1, 8'h00);
      for (int i = 0; i < 300 && (m_acc >> 16) != 64'hF0; i++) idle(1, 1'b1, 8'h00);
      cyc(1, 0, 0, 24'h0, 0, 8'h40);
      cyc(1, 0, 0, 24'h0, 0, 8'h00);
      cyc(1, 0, 1, 24'h020000, 1, 8'h00);
      cyc(0, 1, 0, 24'h0, 0, 8'h00);
      idle(10, 1'b0, 8'h00);
      cyc(1, 0, 1, 24'h010000, 0, 8'h00);
      idle(5, 1'b1, 8'h00);
      cyc(1, 0, 1, 24'h008000, 1, 8'h00);
      idle(3, 1'b1, 8'h00);
      do_reset();
      idle(20, 1'b1, 8'h00);
      for (int i = 0; i < 2500; i++) begin
         logic [23:0] d;
         int          r;
         if (i == 1200) do_reset();
         r = int'($urandom_range(0, 3));
         d = (r == 0) ? 24'h0 : (r == 1) ? 24'($urandom_range(1, 255)) << 16 : 24'($urandom);
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
             d, 1'($urandom), 8'($urandom));
      end
      chk("scoreboard_drained", longint'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
